// File: rtl/fir_sample_packer.sv
// Byte-to-sample packer in front of the FIR core: assembles little-endian bytes
// into 32-bit samples and queues them in a show-ahead FIFO with sticky error flags.
module fir_sample_packer #(
    parameter int BYTES_PER_SAMPLE = 4,
    parameter int DEPTH            = 4,
    parameter int SIGN_EXT         = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    input  logic                     sync,
    input  logic                     take,
    output logic [31:0]              x_dat,
    output logic                     x_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(BYTES_PER_SAMPLE - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] k_eff;
    logic [31:0]   partial;
    logic [31:0]   assembled;
    logic [31:0]   ext_word;
    logic [31:0]   hold;
    logic [31:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          accept;
    logic          complete;
    logic          pop;

    assign level      = wr_ptr - rd_ptr;
    assign full       = (level == (AW+1)'(DEPTH));
    assign x_valid    = (level != '0);
    assign byte_ready = !(full && (cnt == LAST));
    assign accept     = byte_valid && byte_ready;
    // sync restarts the sample, so a byte arriving with it lands in slot 0
    assign k_eff      = sync ? '0 : cnt;
    assign complete   = accept && (k_eff == LAST);
    assign pop        = take && x_valid;
    assign x_dat      = x_valid ? mem[rd_ptr[AW-1:0]] : hold;

    always_comb begin
        assembled = sync ? '0 : partial;
        for (int unsigned k = 0; k < BYTES_PER_SAMPLE; k++) begin
            if (CW'(k) == k_eff) begin
                assembled[8*k +: 8] = byte_in;
            end
        end
    end

    always_comb begin
        ext_word = assembled;
        for (int unsigned i = 8*BYTES_PER_SAMPLE; i < 32; i++) begin
            ext_word[i] = (SIGN_EXT != 0) && assembled[8*BYTES_PER_SAMPLE-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && complete) begin
            mem[wr_ptr[AW-1:0]] <= ext_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            partial   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hold      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (complete) begin
                wr_ptr  <= wr_ptr + 1'b1;
                cnt     <= '0;
                partial <= '0;
            end else if (accept) begin
                partial <= assembled;
                cnt     <= k_eff + 1'b1;
            end else if (sync) begin
                cnt     <= '0;
                partial <= '0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr[AW-1:0]];
            end
            // a set condition in the same cycle overrides clr_flags
            overflow  <= (overflow && !clr_flags) || (byte_valid && !byte_ready);
            underflow <= (underflow && !clr_flags) || (take && !x_valid);
        end
    end

endmodule

// File: tb/tb_fir_sample_packer.sv
// Self-checking bench for fir_sample_packer: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_fir_sample_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        sync = 1'b0;
    logic        take = 1'b0;
    logic [31:0] x_dat;
    logic        x_valid;
    logic [2:0]  level;
    logic        overflow;
    logic        underflow;
    logic        clr_flags = 1'b0;

    // narrow-sample instances (2 bytes, signed and unsigned)
    logic [7:0]  b2_in = '0;
    logic        b2_valid = 1'b0;
    logic        rdy_s, rdy_z, xv_s, xv_z, ov_s, ov_z, un_s, un_z;
    logic [31:0] xd_s, xd_z;
    logic [2:0]  lv_s, lv_z;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  pend [$];
    logic [31:0] mq [$];
    logic [31:0] hold_m;
    logic        ov_m, un_m;

    always #5 clk = ~clk;

    fir_sample_packer #(.BYTES_PER_SAMPLE(4), .DEPTH(4), .SIGN_EXT(0)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .sync(sync), .take(take), .x_dat(x_dat),
        .x_valid(x_valid), .level(level), .overflow(overflow),
        .underflow(underflow), .clr_flags(clr_flags)
    );

    fir_sample_packer #(.BYTES_PER_SAMPLE(2), .DEPTH(4), .SIGN_EXT(1)) dut_s (
        .clk(clk), .rst(rst), .byte_in(b2_in), .byte_valid(b2_valid),
        .byte_ready(rdy_s), .sync(1'b0), .take(1'b0), .x_dat(xd_s),
        .x_valid(xv_s), .level(lv_s), .overflow(ov_s),
        .underflow(un_s), .clr_flags(1'b0)
    );

    fir_sample_packer #(.BYTES_PER_SAMPLE(2), .DEPTH(4), .SIGN_EXT(0)) dut_z (
        .clk(clk), .rst(rst), .byte_in(b2_in), .byte_valid(b2_valid),
        .byte_ready(rdy_z), .sync(1'b0), .take(1'b0), .x_dat(xd_z),
        .x_valid(xv_z), .level(lv_z), .overflow(ov_z),
        .underflow(un_z), .clr_flags(1'b0)
    );

    function automatic logic [31:0] exp_x();
        return (mq.size() != 0) ? mq[0] : hold_m;
    endfunction

    function automatic logic exp_ready();
        return !(mq.size() == 4 && pend.size() == 3);
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, return at negedge.
    task automatic step(input logic bv, input logic [7:0] b, input logic sy,
                        input logic tk, input logic cf);
        logic rdy, ovs, uns;
        byte_valid = bv; byte_in = b; sync = sy; take = tk; clr_flags = cf;
        rdy = exp_ready();
        @(posedge clk);
        ovs = bv && !rdy;
        uns = tk && (mq.size() == 0);
        if (tk && mq.size() != 0) hold_m = mq.pop_front();
        if (sy) pend.delete();
        if (bv && rdy) begin
            pend.push_back(b);
            if (pend.size() == 4) begin
                mq.push_back({pend[3], pend[2], pend[1], pend[0]});
                pend.delete();
            end
        end
        ov_m = (ov_m && !cf) || ovs;
        un_m = (un_m && !cf) || uns;
        @(negedge clk);
        byte_valid = 1'b0; sync = 1'b0; take = 1'b0; clr_flags = 1'b0;
    endtask

    task automatic do_reset(input logic bv, input logic [7:0] b, input logic tk);
        rst = 1'b1; byte_valid = bv; byte_in = b; take = tk;
        @(posedge clk);
        pend.delete(); mq.delete(); hold_m = '0; ov_m = 1'b0; un_m = 1'b0;
        @(negedge clk);
        rst = 1'b0; byte_valid = 1'b0; take = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 8'h00, 1'b0);
        n_cmp += 6;
        if (x_valid !== 1'b0) begin n_err++; $display("FAIL reset_xv got %b want 0", x_valid); end
        if (x_dat !== 32'h0) begin n_err++; $display("FAIL reset_xdat got %h want 0", x_dat); end
        if (level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
        if (byte_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", byte_ready); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ov got %b want 0", overflow); end
        if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_un got %b want 0", underflow); end
    endtask

    task automatic test_basic();
        logic [7:0] seq [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        do_reset(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq[i], 1'b0, 1'b0, 1'b0);
            if (i == 2) begin
                n_cmp++;
                if (x_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_xv got %b want 0", x_valid); end
            end
        end
        n_cmp += 3;
        if (x_valid !== 1'b1) begin n_err++; $display("FAIL basic_xv got %b want 1", x_valid); end
        if (x_dat !== 32'h11223344) begin n_err++; $display("FAIL basic_xdat got %h want 11223344", x_dat); end
        if (level !== 3'd1) begin n_err++; $display("FAIL basic_level got %0d want 1", level); end
    endtask

    task automatic test_narrow();
        do_reset(1'b0, 8'h00, 1'b0);
        b2_valid = 1'b1; b2_in = 8'h34;
        @(posedge clk); @(negedge clk);
        b2_in = 8'h92;
        @(posedge clk); @(negedge clk);
        b2_valid = 1'b0;
        n_cmp += 3;
        if (xd_s !== 32'hFFFF9234) begin n_err++; $display("FAIL narrow_sext got %h want FFFF9234", xd_s); end
        if (xd_z !== 32'h00009234) begin n_err++; $display("FAIL narrow_zext got %h want 00009234", xd_z); end
        if (lv_s !== 3'd1) begin n_err++; $display("FAIL narrow_level got %0d want 1", lv_s); end
    endtask

    task automatic test_full();
        do_reset(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        n_cmp += 3;
        if (byte_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", byte_ready); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL full_ov_early got %b want 0", overflow); end
        if (level !== 3'd4) begin n_err++; $display("FAIL full_level got %0d want 4", level); end
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        n_cmp += 2;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL full_ov got %b want 1", overflow); end
        if (level !== 3'd4) begin n_err++; $display("FAIL full_drop_level got %0d want 4", level); end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_cmp += 3;
        if (byte_ready !== 1'b1) begin n_err++; $display("FAIL full_reready got %b want 1", byte_ready); end
        if (level !== 3'd3) begin n_err++; $display("FAIL full_pop_level got %0d want 3", level); end
        if (x_dat !== exp_x()) begin n_err++; $display("FAIL full_head got %h want %h", x_dat, exp_x()); end
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        n_cmp += 2;
        if (level !== 3'd4) begin n_err++; $display("FAIL full_refill got %0d want 4", level); end
        if (mq[3][31:24] !== 8'h5A) begin n_err++; $display("FAIL full_model_tail got %h want 5a", mq[3][31:24]); end
    endtask

    task automatic test_sync();
        do_reset(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        n_cmp += 2;
        if (x_dat !== 32'h04030201) begin n_err++; $display("FAIL sync_xdat got %h want 04030201", x_dat); end
        if (level !== 3'd1) begin n_err++; $display("FAIL sync_level got %0d want 1", level); end
        step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        for (int i = 2; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        n_cmp += 2;
        if (x_dat !== 32'h04030201) begin n_err++; $display("FAIL sync_byte0 got %h want 04030201", x_dat); end
        if (x_dat !== exp_x()) begin n_err++; $display("FAIL sync_model got %h want %h", x_dat, exp_x()); end
    endtask

    task automatic test_underflow();
        logic [7:0] seq [4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        do_reset(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, seq[i], 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_cmp += 3;
        if (x_valid !== 1'b0) begin n_err++; $display("FAIL uf_pop_xv got %b want 0", x_valid); end
        if (x_dat !== 32'hCAFEF00D) begin n_err++; $display("FAIL uf_hold got %h want cafef00d", x_dat); end
        if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_early got %b want 0", underflow); end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        n_cmp += 3;
        if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set got %b want 1", underflow); end
        if (x_dat !== 32'hCAFEF00D) begin n_err++; $display("FAIL uf_xdat got %h want cafef00d", x_dat); end
        if (level !== 3'd0) begin n_err++; $display("FAIL uf_level got %0d want 0", level); end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set_wins got %b want 1", underflow); end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_clear got %b want 0", underflow); end
    endtask

    task automatic test_rst_mid();
        logic [7:0] b [4];
        do_reset(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
        do_reset(1'b1, 8'h77, 1'b1);
        n_cmp += 5;
        if (x_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_xv got %b want 0", x_valid); end
        if (x_dat !== 32'h0) begin n_err++; $display("FAIL rst_mid_xdat got %h want 0", x_dat); end
        if (level !== 3'd0) begin n_err++; $display("FAIL rst_mid_level got %0d want 0", level); end
        if (byte_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready got %b want 1", byte_ready); end
        if (underflow !== 1'b0) begin n_err++; $display("FAIL rst_mid_un got %b want 0", underflow); end
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'($urandom);
            step(1'b1, b[i], 1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        if (x_dat !== {b[3], b[2], b[1], b[0]}) begin
            n_err++; $display("FAIL rst_mid_fresh got %h want %h", x_dat, {b[3], b[2], b[1], b[0]});
        end
    endtask

    task automatic test_random();
        do_reset(1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
            n_cmp += 6;
            if (x_dat !== exp_x()) begin n_err++; $display("FAIL rnd_xdat c=%0d got %h want %h", c, x_dat, exp_x()); end
            if (x_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_xv c=%0d got %b want %b", c, x_valid, mq.size() != 0); end
            if (level !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_level c=%0d got %0d want %0d", c, level, mq.size()); end
            if (byte_ready !== exp_ready()) begin n_err++; $display("FAIL rnd_ready c=%0d got %b want %b", c, byte_ready, exp_ready()); end
            if (overflow !== ov_m) begin n_err++; $display("FAIL rnd_ov c=%0d got %b want %b", c, overflow, ov_m); end
            if (underflow !== un_m) begin n_err++; $display("FAIL rnd_un c=%0d got %b want %b", c, underflow, un_m); end
        end
    endtask

    initial begin
        hold_m = '0; ov_m = 1'b0; un_m = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_narrow();
        test_full();
        test_sync();
        test_underflow();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
